register_file: RTL and testbench

- General-purpose register file for the datapath: 2^ADDR_WIDTH registers of DATA_WIDTH bits each.
- Two independent combinational read ports and one synchronous write port.
- Sits between instruction decode (read addresses) and writeback (write address/data/enable).
- Register 0 is hardwired to zero.

---
 rtl/register_file_pkg.sv | 13 +
 rtl/register_file_read_port.sv | 48 ++++
 rtl/register_file.sv | 67 ++++++
 tb/tb_register_file.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Register file shared constants and types.
// Optional write-through bypass: REGISTER_FILE_WRITE_BYPASS_EN.
package register_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_word_t;
  typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_addr_t;

  localparam int ZERO_REG_ADDR = 0;

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: array mux, zero register,
// and write-through bypass under REGISTER_FILE_WRITE_BYPASS_EN.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  localparam int NUM_REGS = 1 << ADDR_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] regs [NUM_REGS],
  input  logic [ADDR_WIDTH-1:0] ra,
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
`endif
  output logic [DATA_WIDTH-1:0] data
);

  logic is_zero;

  assign is_zero = (ra == ADDR_WIDTH'(ZERO_REG_ADDR));

`ifdef REGISTER_FILE_WRITE_BYPASS_EN
  logic fwd;

  // A write to r0 never forwards, because is_zero wins below.
  assign fwd = we && !reset && (wa == ra);

  always_comb begin
    data = regs[ra];
    if (is_zero) begin
      data = '0;
    end else if (fwd) begin
      data = wd;
    end
  end
`else
  always_comb begin
    data = regs[ra];
    if (is_zero) begin
      data = '0;
    end
  end
`endif

endmodule

// File: rtl/register_file.sv
// 2-read / 1-write register file with r0 hardwired to zero.
// Optional write-through bypass: REGISTER_FILE_WRITE_BYPASS_EN.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ra0,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic [DATA_WIDTH-1:0] out0,
  output logic [DATA_WIDTH-1:0] out1
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  wr_en;

  assign wr_en = we && (wa != ADDR_WIDTH'(ZERO_REG_ADDR));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  register_file_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_rp0 (
    .regs (regs),
    .ra   (ra0),
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
    .reset(reset),
    .we   (we),
    .wa   (wa),
    .wd   (wd),
`endif
    .data (out0)
  );

  register_file_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_rp1 (
    .regs (regs),
    .ra   (ra1),
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
    .reset(reset),
    .we   (we),
    .wa   (wa),
    .wd   (wd),
`endif
    .data (out1)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file (both bypass builds).
// Vector table, directed corner cases, random vs reference model.
module tb_register_file;
  import register_file_pkg::*;

  logic      clock = 1'b0;
  logic      reset = 1'b1;
  reg_addr_t ra0 = '0;
  reg_addr_t ra1 = '0;
  logic      we = 1'b0;
  reg_addr_t wa = '0;
  reg_word_t wd = '0;
  reg_word_t out0;
  reg_word_t out1;

  int tests = 0;
  int fails = 0;

  reg_word_t model [32];

  register_file dut (
    .clock(clock),
    .reset(reset),
    .ra0  (ra0),
    .ra1  (ra1),
    .we   (we),
    .wa   (wa),
    .wd   (wd),
    .out0 (out0),
    .out1 (out1)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic      we;
    reg_addr_t wa;
    reg_word_t wd;
    reg_addr_t ra0;
    reg_addr_t ra1;
    reg_word_t exp0;
    reg_word_t exp1;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input reg_word_t got,
                       input reg_word_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Model of the stored array; pre-edge inputs decide the update.
  task automatic clk_step();
    logic      r, w;
    reg_addr_t a;
    reg_word_t d;
    r = reset; w = we; a = wa; d = wd;
    @(posedge clock);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (w && a != 0) begin
      model[a] = d;
    end
    #1;
  endtask

  function automatic reg_word_t exp_read(input reg_addr_t ra);
    if (ra == 0) return '0;
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
    if (we && !reset && wa == ra) return wd;
`endif
    return model[ra];
  endfunction

  task automatic write(input reg_addr_t a, input reg_word_t d);
    we = 1'b1; wa = a; wd = d;
    clk_step();
    we = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd25, 32'd10,         5'd25, 5'd0,  32'd10, 32'd0};
    vecs[1] = '{1'b0, 5'd12, 32'd1024,       5'd12, 5'd25, 32'd0,  32'd10};
    vecs[2] = '{1'b1, 5'd12, 32'd1024,       5'd25, 5'd12, 32'd10, 32'd1024};
    vecs[3] = '{1'b1, 5'd0,  32'hDEADBEEF,   5'd0,  5'd12, 32'd0,  32'd1024};

    // Reset, then sweep every address on both ports.
    reset = 1'b1;
    clk_step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra0 = reg_addr_t'(i);
      ra1 = reg_addr_t'(31 - i);
      #1;
      check($sformatf("reset_out0[%0d]", i), out0, '0);
      check($sformatf("reset_out1[%0d]", 31 - i), out1, '0);
    end

    // Table vectors: one edge with the write fields, then read back.
    for (int i = 0; i < 4; i++) begin
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      clk_step();
      we = 1'b0;
      ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
      #1;
      check($sformatf("vec%0d_out0", i), out0, vecs[i].exp0);
      check($sformatf("vec%0d_out1", i), out1, vecs[i].exp1);
    end

    // Reset beats a write in the same cycle.
    write(5'd7, 32'd5);
    ra0 = 5'd7;
    #1;
    check("pre_reset_r7", out0, 32'd5);
    reset = 1'b1; we = 1'b1; wa = 5'd7; wd = 32'd99;
    clk_step();
    reset = 1'b0; we = 1'b0;
    #1;
    check("reset_prio_r7", out0, 32'd0);
    ra1 = 5'd25;
    #1;
    check("reset_clears_r25", out1, 32'd0);

    // Read-during-write on both ports.
    write(5'd3, 32'd1);
    we = 1'b1; wa = 5'd3; wd = 32'd2; ra0 = 5'd3; ra1 = 5'd3;
    #1;
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
    check("rdw_pre_out0", out0, 32'd2);
    check("rdw_pre_out1", out1, 32'd2);
`else
    check("rdw_pre_out0", out0, 32'd1);
    check("rdw_pre_out1", out1, 32'd1);
`endif
    clk_step();
    we = 1'b0;
    #1;
    check("rdw_post_out0", out0, 32'd2);
    check("rdw_post_out1", out1, 32'd2);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 40) == 0);
      we    = $urandom_range(0, 1) == 1;
      wa    = reg_addr_t'($urandom_range(0, 31));
      wd    = $urandom;
      ra0   = (n % 4 == 0) ? wa : reg_addr_t'($urandom_range(0, 31));
      ra1   = (n % 5 == 0) ? wa : reg_addr_t'($urandom_range(0, 31));
      #1;
      check($sformatf("rnd%0d_out0", n), out0, exp_read(ra0));
      check($sformatf("rnd%0d_out1", n), out1, exp_read(ra1));
      clk_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
